// File: rtl/pwm_capture.sv
`timescale 1ns/1ps
// pwm_capture: measures the period and high time of an asynchronous PWM
// input in clk cycles, one result per PWM cycle, and flags an input that
// stays static (high or low) for TIMEOUT cycles.
//
// Handshake: meas_valid is a one-cycle strobe with no back-pressure; period
// and h_time are valid in the cycle meas_valid is high and hold afterwards.
module pwm_capture #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] h_time,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEASURE   = 2'd2
  } state_e;

  state_e           state_q, state_d;

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] h_time_q, h_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             stuck_high_q, stuck_high_d;
  logic             stuck_low_q, stuck_low_d;

  logic             rise;
  logic             fall;
  logic             stuck_any;
  logic             timeout_hit;

  // FSM-derived controls for the datapath
  logic             take_meas;
  logic             take_timeout;
  logic             clr_cnt;
  logic             clr_stuck;

  // Counters stop at full scale rather than wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign rise        = s2_q & ~s3_q;
  assign fall        = ~s2_q & s3_q;
  assign stuck_any   = stuck_high_q | stuck_low_q;
  // A rise in the same cycle always wins over the timeout; once flagged,
  // the timeout stays quiet until a rise or en low clears the flags.
  assign timeout_hit = (state_q != ST_IDLE) && !rise && !stuck_any &&
                       (per_cnt_q >= TO_VAL);

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; en low returns to IDLE from any state
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_WAIT_RISE;
        ST_WAIT_RISE: if (rise) state_d = ST_MEASURE;
        ST_MEASURE: begin
          if (rise) begin
            state_d = ST_MEASURE;
          end else if (timeout_hit) begin
            state_d = ST_WAIT_RISE;
          end
        end
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: which datapath action happens this cycle
  always_comb begin
    take_meas    = 1'b0;
    take_timeout = 1'b0;
    clr_cnt      = 1'b1;
    clr_stuck    = 1'b1;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          clr_cnt   = 1'b1;
          clr_stuck = 1'b1;
        end
        ST_WAIT_RISE: begin
          clr_cnt      = 1'b0;
          clr_stuck    = rise;
          take_timeout = timeout_hit;
        end
        ST_MEASURE: begin
          clr_cnt      = 1'b0;
          clr_stuck    = rise;
          take_meas    = rise;
          take_timeout = timeout_hit;
        end
        default: begin
          clr_cnt   = 1'b1;
          clr_stuck = 1'b1;
        end
      endcase
    end
  end

  // Datapath next values: synchronizer, counters, results and flags
  always_comb begin
    s1_d         = pwm_in;
    s2_d         = s1_q;
    s3_d         = s2_q;
    per_cnt_d    = per_cnt_q;
    hi_cnt_d     = hi_cnt_q;
    hi_lat_d     = hi_lat_q;
    period_d     = period_q;
    h_time_d     = h_time_q;
    meas_valid_d = 1'b0;
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;

    if (clr_cnt) begin
      per_cnt_d = '0;
      hi_cnt_d  = '0;
      hi_lat_d  = '0;
    end else begin
      if (rise) begin
        per_cnt_d = CNT_ONE;
        hi_cnt_d  = CNT_ONE;
      end else begin
        per_cnt_d = sat_inc(per_cnt_q);
        if (s2_q) begin
          hi_cnt_d = sat_inc(hi_cnt_q);
        end
      end
      if (fall) begin
        hi_lat_d = hi_cnt_q;
      end
    end

    if (take_meas) begin
      period_d     = per_cnt_q;
      // hi_lat can never legitimately exceed the period; clamp keeps the
      // h_time <= period guarantee unconditional.
      h_time_d     = (hi_lat_q > per_cnt_q) ? per_cnt_q : hi_lat_q;
      meas_valid_d = 1'b1;
    end else if (take_timeout) begin
      period_d     = '0;
      h_time_d     = '0;
      meas_valid_d = 1'b1;
      stuck_high_d = s2_q;
      stuck_low_d  = ~s2_q;
    end

    if (clr_stuck) begin
      stuck_high_d = 1'b0;
      stuck_low_d  = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      hi_lat_q     <= '0;
      period_q     <= '0;
      h_time_q     <= '0;
      meas_valid_q <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      hi_lat_q     <= hi_lat_d;
      period_q     <= period_d;
      h_time_q     <= h_time_d;
      meas_valid_q <= meas_valid_d;
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
    end
  end

  assign period     = period_q;
  assign h_time     = h_time_q;
  assign meas_valid = meas_valid_q;
  assign stuck_high = stuck_high_q;
  assign stuck_low  = stuck_low_q;

endmodule
